// File: rtl/parity_frame_scheduler.sv
// Two-requester round-robin scheduler that serializes WIDTH-bit words LSB first and reports their parity.
// Optional build macro PARITY_ERR_CHECK_EN adds per-requester expected-parity inputs and a parity_err output.
module parity_frame_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req1_data,
`ifdef PARITY_ERR_CHECK_EN
  input  logic             req0_exp,
  input  logic             req1_exp,
  output logic             parity_err,
`endif
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             ser_x,
  output logic             ser_valid,
  output logic             done,
  output logic             parity_z,
  output logic             grant_id,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             parity_run;
  logic             last_grant;
  logic             grant_sel;
  logic             accept;

  // Round-robin only matters on contention; a lone requester always wins.
  always_comb begin
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else if (req1_valid) begin
      grant_sel = 1'b1;
    end
  end

  assign accept     = reset_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_sel;
  assign req1_ready = accept && grant_sel;

  assign ser_valid = (state == SHIFT);
  assign ser_x     = (state == SHIFT) && shreg[0];
  assign done      = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);

`ifdef PARITY_ERR_CHECK_EN
  logic exp_bit;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      exp_bit <= 1'b0;
    end else if (accept) begin
      exp_bit <= grant_sel ? req1_exp : req0_exp;
    end
  end

  assign parity_err = (state == DONE) && (parity_z ^ exp_bit);
`endif

  // parity_z is loaded on the final shift so it is ready in DONE and then holds.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_run <= 1'b0;
      parity_z   <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= grant_sel ? req1_data : req0_data;
            bit_cnt    <= '0;
            parity_run <= 1'b0;
            grant_id   <= grant_sel;
            last_grant <= grant_sel;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          parity_run <= parity_run ^ shreg[0];
          shreg      <= shreg >> 1;
          bit_cnt    <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            parity_z <= parity_run ^ shreg[0];
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// Directed bench for parity_frame_scheduler; inputs change and outputs are sampled mid-cycle on the falling edge.
// Define PARITY_ERR_CHECK_EN to also exercise the parity_err feature.
module tb_parity_frame_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       ser_x, ser_valid, done, parity_z, grant_id, busy;
`ifdef PARITY_ERR_CHECK_EN
  logic       req0_exp, req1_exp, parity_err;
`endif

  int         n_compared   = 0;
  int         n_mismatched = 0;
  logic [7:0] exp_bits;

  always #5 clock = ~clock;

  parity_frame_scheduler #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
`ifdef PARITY_ERR_CHECK_EN
    .req0_exp   (req0_exp),
    .req1_exp   (req1_exp),
    .parity_err (parity_err),
`endif
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .ser_x      (ser_x),
    .ser_valid  (ser_valid),
    .done       (done),
    .parity_z   (parity_z),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // Each call advances to the next cycle, drives the requesters and lets combinational outputs settle.
  task automatic apply_stimulus(input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1);
    @(negedge clock);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
`ifdef PARITY_ERR_CHECK_EN
    req0_exp   = 1'b0;
    req1_exp   = 1'b0;
`endif

    // Reset state, with requests pending that must not be acknowledged
    apply_stimulus(1'b1, 8'hAA, 1'b1, 8'h55);
    check_output("rst_ready0", req0_ready, 0);
    check_output("rst_ready1", req1_ready, 0);
    check_output("rst_ser_valid", ser_valid, 0);
    check_output("rst_ser_x", ser_x, 0);
    check_output("rst_done", done, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_parity_z", parity_z, 0);
    check_output("rst_grant_id", grant_id, 0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    reset_n = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("idle_ready0", req0_ready, 0);
    check_output("idle_ser_valid", ser_valid, 0);
    check_output("idle_done", done, 0);

    // req0 alone with 8'hEE; data and req1 wiggle during SHIFT and must be ignored
    exp_bits = 8'hEE;
    apply_stimulus(1'b1, 8'hEE, 1'b0, 8'h00);
    check_output("a_ready0", req0_ready, 1);
    check_output("a_ready1", req1_ready, 0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 8'h00, (i == 2), 8'hFF);
      check_output($sformatf("a_ser_valid%0d", i), ser_valid, 1);
      check_output($sformatf("a_ser_x%0d", i), ser_x, exp_bits[i]);
      check_output($sformatf("a_busy%0d", i), busy, 1);
      if (i == 2) check_output("a_ignore_req1", req1_ready, 0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("a_done", done, 1);
    check_output("a_parity_z", parity_z, 0);
    check_output("a_grant_id", grant_id, 0);
    check_output("a_done_ser_valid", ser_valid, 0);
    check_output("a_done_busy", busy, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("a_done_pulse", done, 0);
    check_output("a_idle_busy", busy, 0);

    // req1 alone with 8'h07 -> odd parity
    apply_stimulus(1'b0, 8'h00, 1'b1, 8'h07);
    check_output("b_ready1", req1_ready, 1);
    check_output("b_ready0", req0_ready, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("b_done", done, 1);
    check_output("b_parity_z", parity_z, 1);
    check_output("b_grant_id", grant_id, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("b_done_pulse", done, 0);
    check_output("b_parity_hold", parity_z, 1);
    check_output("b_grant_hold", grant_id, 1);

    // Contention right after reset: req0 first, then alternating every WIDTH+2 cycles
    reset_n = 1'b0;
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("c_rst_parity_z", parity_z, 0);
    check_output("c_rst_grant_id", grant_id, 0);
    reset_n = 1'b1;
    apply_stimulus(1'b1, 8'h01, 1'b1, 8'h03);
    check_output("c_first_ready0", req0_ready, 1);
    check_output("c_first_ready1", req1_ready, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'h01, 1'b1, 8'h03);
    apply_stimulus(1'b1, 8'h01, 1'b1, 8'h03);
    check_output("c_done0", done, 1);
    check_output("c_parity0", parity_z, 1);
    check_output("c_grant0", grant_id, 0);
    check_output("c_done_ready0", req0_ready, 0);
    apply_stimulus(1'b1, 8'h01, 1'b1, 8'h03);
    check_output("c_second_ready1", req1_ready, 1);
    check_output("c_second_ready0", req0_ready, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'h01, 1'b1, 8'h03);
    apply_stimulus(1'b1, 8'h01, 1'b1, 8'h03);
    check_output("c_done1", done, 1);
    check_output("c_parity1", parity_z, 0);
    check_output("c_grant1", grant_id, 1);
    apply_stimulus(1'b1, 8'h01, 1'b1, 8'h03);
    check_output("c_third_ready0", req0_ready, 1);
    check_output("c_third_ready1", req1_ready, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("c_done2", done, 1);
    check_output("c_parity2", parity_z, 1);
    check_output("c_grant2", grant_id, 0);

    // Reset asserted during the 4th SHIFT cycle aborts the frame silently
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b1, 8'hEE, 1'b0, 8'h00);
    check_output("d_ready0", req0_ready, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("d_shift4_valid", ser_valid, 1);
    reset_n = 1'b0;
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("d_abort_busy", busy, 0);
    check_output("d_abort_ser_valid", ser_valid, 0);
    check_output("d_abort_ser_x", ser_x, 0);
    check_output("d_abort_done", done, 0);
    check_output("d_abort_parity_z", parity_z, 0);
    check_output("d_abort_grant_id", grant_id, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
      check_output($sformatf("d_no_done%0d", i), done, 0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1, 8'h03);
    check_output("d_new_ready1", req1_ready, 1);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("d_new_done", done, 1);
    check_output("d_new_parity", parity_z, 0);
    check_output("d_new_grant", grant_id, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);

`ifdef PARITY_ERR_CHECK_EN
    // Expected-parity check: 8'h07 has odd parity, so exp=0 flags an error and exp=1 does not
    req0_exp = 1'b0;
    apply_stimulus(1'b1, 8'h07, 1'b0, 8'h00);
    req0_exp = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("e_err_shift", parity_err, 0);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("e_done0", done, 1);
    check_output("e_err0", parity_err, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("e_err_idle", parity_err, 0);
    req0_exp = 1'b1;
    apply_stimulus(1'b1, 8'h07, 1'b0, 8'h00);
    req0_exp = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    check_output("e_done1", done, 1);
    check_output("e_parity1", parity_z, 1);
    check_output("e_err1", parity_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/parity_frame_scheduler.md
PARITY_FRAME_SCHEDULER -- requirements
Module: parity_frame_scheduler

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data word width in bits (legal 2..32).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports: req0_valid, req1_valid  input  1 each  requester has a word pending.
REQ-005 SHALL have ports: req0_data, req1_data  input  WIDTH each  requester words.
REQ-006 SHALL have ports: req0_ready, req1_ready  output  1 each  accept strobe; word taken on the cycle ready=1 and valid=1.
REQ-007 SHALL have port: ser_x  output  1  current serialized bit, LSB first.
REQ-008 SHALL have port: ser_valid  output  1  ser_x carries a frame bit.
REQ-009 SHALL have port: done  output  1  one-cycle frame-complete pulse.
REQ-010 SHALL have port: parity_z  output  1  XOR of all WIDTH bits of the finished frame; 1 = odd parity; valid while done=1.
REQ-011 SHALL have port: grant_id  output  1  requester of the current or last frame.
REQ-012 SHALL have port: busy  output  1  high in SHIFT and DONE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE: with no valid request, SHALL stay in IDLE with ready, ser_valid and done all 0.
REQ-015 IDLE with a valid request: SHALL assert exactly one ready combinationally, capture that word into the shift register, clear running parity and bit counter, set grant_id, and go to SHIFT.
REQ-016 Arbitration SHALL be round-robin: when both requests are valid, grant the requester not granted last; the last-granted register resets to 1, so req0 wins first.
REQ-017 With a single valid request, SHALL grant it regardless of round-robin state.
REQ-018 SHIFT: each cycle SHALL drive ser_valid=1, drive ser_x=shreg[0], XOR the bit into running parity, shift right, and increment the counter.
REQ-019 SHIFT SHALL last exactly WIDTH cycles, then go to DONE.
REQ-020 DONE: SHALL assert done=1 and parity_z for exactly one cycle, then return to IDLE.
REQ-021 Latency: for a word accepted in cycle N, the bits SHALL appear in cycles N+1..N+WIDTH and done in cycle N+WIDTH+1.
REQ-022 Accept gap: the earliest next accept SHALL be cycle N+WIDTH+2, giving a minimum spacing of WIDTH+2 cycles between accepts.
REQ-023 SHALL ignore request inputs outside IDLE; a requester's data is sampled only on its accept cycle.
REQ-024 parity_z SHALL hold its last value outside DONE; grant_id SHALL hold until the next accept.

Reset
REQ-025 While reset_n=0 at a rising edge, SHALL enter IDLE and clear ser_x, ser_valid, done, parity_z, grant_id, shreg and counter to 0, and set last-grant to 1.
REQ-026 Reset mid-frame SHALL abort the frame with no done pulse; the aborted word is discarded, not re-requested.
REQ-027 req0_ready and req1_ready SHALL be 0 while reset_n=0.

Configuration
REQ-028 Macro PARITY_ERR_CHECK_EN: when defined, SHALL add inputs req0_exp and req1_exp (1 bit each, sampled at accept) and an output parity_err (1 bit) that equals parity_z XOR the captured expected bit during DONE and is 0 otherwise, cleared by reset.
REQ-029 When PARITY_ERR_CHECK_EN is undefined, those ports and that logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-030 Test: req0 only, data 8'b1110_1110, accepted cycle N -> ser_x=0,1,1,1,0,1,1,1 in cycles N+1..N+8; done at N+9; parity_z=0; grant_id=0.
REQ-031 Test: req1 only, data 8'h07 -> parity_z=1 and grant_id=1 at done.
REQ-032 Test: both valid after reset, req0=8'h01, req1=8'h03, held -> req0 accepted first (parity 1), req1 accepted at cycle N+10 (parity 0), alternating thereafter.
REQ-033 Test: reset_n=0 during the 4th SHIFT cycle -> next cycle IDLE, all outputs 0, no done; a new request is then accepted normally.
REQ-034 Test: change req0_data during SHIFT -> the frame reflects only the word captured at accept.
REQ-035 Test (PARITY_ERR_CHECK_EN): data 8'h07 with exp=0 -> parity_err=1 during DONE; with exp=1 -> parity_err=0.
